// File: rtl/keypad_scan_sequencer_if.sv
// Key delivery handshake between the keypad scan sequencer and the calculator FSM.
interface keypad_scan_sequencer_if;
   logic [3:0] KeyCode;
   logic       KeyValid;
   logic       KeyReady;

   modport master (output KeyCode, output KeyValid, input KeyReady);
   modport slave  (input KeyCode, input KeyValid, output KeyReady);
endinterface

// File: rtl/keypad_scan_sequencer.sv
// 4x4 keypad scan sequencer: drives one column at a time, debounces press and
// release, and hands each accepted key to the consumer exactly once.
module keypad_scan_sequencer #(
   parameter int unsigned SETTLE_CYCLES   = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           EnableKeyb,
   input  logic [3:0]                     keyboardfil,
   output logic [3:0]                     keyboardcol,
   output logic                           Busy,
   output logic [2:0]                     state,
   keypad_scan_sequencer_if.master        key_if
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SCAN      = 3'd1,
      SETTLE    = 3'd2,
      DEB_PRESS = 3'd3,
      PRESENT   = 3'd4,
      WAIT_REL  = 3'd5,
      DEB_REL   = 3'd6
   } state_t;

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [15:0] DEB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  col_q;
   logic [1:0]  row_q;
   logic [7:0]  settle_cnt;
   logic [15:0] deb_cnt;

   logic [1:0]  row_lo;
   logic        row_hit;
   logic [1:0]  col_next;

   function automatic logic [3:0] onehot(input logic [1:0] c);
      return 4'(4'b0001 << c);
   endfunction

   // Lowest active row wins when several keys share the driven column.
   always_comb begin
      row_lo = 2'd3;
      if (keyboardfil[0])      row_lo = 2'd0;
      else if (keyboardfil[1]) row_lo = 2'd1;
      else if (keyboardfil[2]) row_lo = 2'd2;
      row_hit  = keyboardfil[row_q];
      col_next = col_q + 2'd1;
   end

   // Scan/debounce/handshake state machine with registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q         <= IDLE;
         col_q           <= '0;
         row_q           <= '0;
         settle_cnt      <= '0;
         deb_cnt         <= '0;
         keyboardcol     <= '0;
         key_if.KeyCode  <= '0;
         key_if.KeyValid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               keyboardcol <= '0;
               if (EnableKeyb) begin
                  col_q       <= '0;
                  settle_cnt  <= '0;
                  keyboardcol <= 4'b0001;
                  state_q     <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) state_q <= SCAN;
               else                           settle_cnt <= settle_cnt + 8'd1;
            end
            SCAN: begin
               if (!EnableKeyb) begin
                  keyboardcol <= '0;
                  state_q     <= IDLE;
               end else if (|keyboardfil) begin
                  row_q   <= row_lo;
                  deb_cnt <= '0;
                  state_q <= DEB_PRESS;
               end else begin
                  col_q       <= col_next;
                  settle_cnt  <= '0;
                  keyboardcol <= onehot(col_next);
                  state_q     <= SETTLE;
               end
            end
            DEB_PRESS: begin
               if (row_hit) begin
                  if (deb_cnt == DEB_LAST) begin
                     key_if.KeyCode  <= {col_q, row_q};
                     key_if.KeyValid <= 1'b1;
                     state_q         <= PRESENT;
                  end else begin
                     deb_cnt <= deb_cnt + 16'd1;
                  end
               end else begin
                  col_q       <= col_next;
                  settle_cnt  <= '0;
                  keyboardcol <= onehot(col_next);
                  state_q     <= SETTLE;
               end
            end
            PRESENT: begin
               if (key_if.KeyReady) begin
                  key_if.KeyValid <= 1'b0;
                  state_q         <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!row_hit) begin
                  deb_cnt <= '0;
                  state_q <= DEB_REL;
               end
            end
            DEB_REL: begin
               if (row_hit) begin
                  state_q <= WAIT_REL;
               end else if (deb_cnt == DEB_LAST) begin
                  col_q <= col_next;
                  if (EnableKeyb) begin
                     settle_cnt  <= '0;
                     keyboardcol <= onehot(col_next);
                     state_q     <= SETTLE;
                  end else begin
                     keyboardcol <= '0;
                     state_q     <= IDLE;
                  end
               end else begin
                  deb_cnt <= deb_cnt + 16'd1;
               end
            end
            default: begin
               keyboardcol <= '0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign Busy  = (state_q != IDLE) && (state_q != SCAN);
   assign state = state_q;

endmodule
